// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard unit: forwarding selects and
// memory wait-state FSM states.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR  = 2'b10
  } mem_state_e;

endpackage

// File: rtl/mem_wait_fsm.sv
// Wait-state tracker for a variable-latency data memory: holds the pipeline
// while an access is outstanding and latches a sticky error on timeout.
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic MemReqM,
  input  logic MemReadyM,
  output logic ms_c,
  output logic MemErr
);

  localparam int unsigned CNT_BITS = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(MAX_WAIT);

  mem_state_e          r_state;
  mem_state_e          w_state_nxt;
  logic [CNT_BITS-1:0] r_cnt;
  logic [CNT_BITS-1:0] w_cnt_nxt;
  logic                r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= (w_state_nxt == ST_ERR);
    end
  end

  // ms_c covers the first miss cycle in IDLE too, so a stall starts immediately
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    ms_c        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (MemReqM && !MemReadyM) begin
          ms_c        = 1'b1;
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = CNT_BITS'(1);
        end
      end
      ST_WAIT: begin
        if (MemReadyM) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          ms_c        = 1'b1;
          w_state_nxt = ST_ERR;
        end else begin
          ms_c      = 1'b1;
          w_cnt_nxt = r_cnt + CNT_BITS'(1);
        end
      end
      ST_ERR: begin
        ms_c = 1'b1;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign MemErr = r_err;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage RV32 pipeline: forwarding selects, load-use
// stall, branch flush, memory wait-state stall and a stall-cycle counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MAX_WAIT   = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic [REG_ADDR_W-1:0] RD_M,
  input  logic [REG_ADDR_W-1:0] RD_W,
  input  logic [REG_ADDR_W-1:0] RD_E,
  input  logic                  ResultSrcE,
  input  logic [REG_ADDR_W-1:0] Rs1_E,
  input  logic [REG_ADDR_W-1:0] Rs2_E,
  input  logic [REG_ADDR_W-1:0] Rs1_D,
  input  logic [REG_ADDR_W-1:0] Rs2_D,
  input  logic                  PCSrcE,
  input  logic                  MemReqM,
  input  logic                  MemReadyM,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
  output logic                  MemErr,
  output logic [CNT_W-1:0]      StallCount
);

  logic             w_ms_raw;
  logic             w_ms;
  logic             w_lu;
  logic [CNT_W-1:0] r_stall_cnt;

  mem_wait_fsm #(
    .MAX_WAIT (MAX_WAIT)
  ) u_mem_wait (
    .clk       (clk),
    .rst       (rst),
    .MemReqM   (MemReqM),
    .MemReadyM (MemReadyM),
    .ms_c      (w_ms_raw),
    .MemErr    (MemErr)
  );

  function automatic logic [1:0] fwd_sel(
    input logic                  wr_m,
    input logic [REG_ADDR_W-1:0] rd_m,
    input logic                  wr_w,
    input logic [REG_ADDR_W-1:0] rd_w,
    input logic [REG_ADDR_W-1:0] rs
  );
    if (wr_m && (rd_m != '0) && (rd_m == rs)) begin
      return FWD_M;
    end else if (wr_w && (rd_w != '0) && (rd_w == rs)) begin
      return FWD_W;
    end
    return FWD_RF;
  endfunction

  assign w_ms = rst && w_ms_raw;
  assign w_lu = ResultSrcE && (RD_E != '0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));

  // Priority: memory stall masks branch, branch masks load-use (wrong-path D)
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    if (rst) begin
      ForwardAE = fwd_sel(RegWriteM, RD_M, RegWriteW, RD_W, Rs1_E);
      ForwardBE = fwd_sel(RegWriteM, RD_M, RegWriteW, RD_W, Rs2_E);
      if (w_ms) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (w_lu) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (StallF && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign StallCount = r_stall_cnt;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Second-generation hazard unit for the 5-stage RV32 pipeline. It generates the forwarding selects as before, and adds:
- load-use stall detection;
- branch flush;
- a wait-state FSM for a variable-latency data memory, with a timeout error;
- a saturating stall-cycle counter.

It sits beside the stage modules in the pipeline top and drives stall/flush enables on the F/D, D/E, E/M and M/W pipeline registers.

Parameters:
REG_ADDR_W, 5, register index width
MAX_WAIT, 8, max WAIT-state cycles before timeout (>=1)
CNT_W, 16, width of stall-cycle counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
RegWriteM  in  1  M-stage writes register file
RegWriteW  in  1  W-stage writes register file
RD_M  in  REG_ADDR_W  M-stage destination
RD_W  in  REG_ADDR_W  W-stage destination
RD_E  in  REG_ADDR_W  E-stage destination
ResultSrcE  in  1  E-stage instruction is a load
Rs1_E, Rs2_E  in  REG_ADDR_W each  E-stage sources
Rs1_D, Rs2_D  in  REG_ADDR_W each  D-stage sources
PCSrcE  in  1  branch/jump taken in E
MemReqM  in  1  M-stage load/store active
MemReadyM  in  1  data memory completes access this cycle
ForwardAE, ForwardBE  out  2  00 = regfile, 01 = ResultW, 10 = ALU_ResultM
StallF, StallD, StallE, StallM  out  1  hold pipeline register
FlushD, FlushE, FlushW  out  1  insert bubble
MemErr  out  1  sticky memory timeout
StallCount  out  CNT_W  saturating count of cycles with StallF=1

Behaviour:
- Reset (rst=0, async):
  - FSM goes to IDLE; wait counter, MemErr and StallCount clear to 0.
  - While rst=0, all combinational outputs are forced to 0.
- Forwarding (combinational, per source):
  - 10 if RegWriteM && RD_M!=0 && RD_M==Rs.
  - Else 01 if RegWriteW && RD_W!=0 && RD_W==Rs.
  - Else 00. M has priority when both match.
- Load-use (combinational): lu = ResultSrcE && RD_E!=0 && (RD_E==Rs1_D || RD_E==Rs2_D).
  - Gives StallF=StallD=1 and FlushE=1 for that cycle (one bubble).
- Branch: PCSrcE=1 gives FlushD=FlushE=1. Branch overrides load-use: StallF/StallD stay 0 because the D instruction is wrong-path.
- Memory FSM, states IDLE, WAIT, ERR; cnt is log2(MAX_WAIT+1) bits.
  - IDLE: MemReqM && !MemReadyM gives ms=1 this cycle; next state WAIT, cnt<=1.
  - WAIT, MemReadyM=1: ms=0 this cycle; next IDLE, cnt<=0.
  - WAIT, !MemReadyM and cnt==MAX_WAIT: ms=1; next ERR.
  - WAIT, otherwise: ms=1, cnt<=cnt+1.
  - ERR: ms=1 permanently and MemErr=1; leaves only on reset.
  - Net effect: an access with no ready gets MAX_WAIT+1 stall cycles, then ERR.
- When ms=1:
  - StallF=StallD=StallE=StallM=1 and FlushW=1.
  - FlushD/FlushE are forced to 0. Load-use and branch effects are masked; E is held, so they re-evaluate after release.
- When ms=0: StallE=StallM=FlushW=0.
- StallCount increments on each clk edge where StallF=1 and holds at 2^CNT_W-1.
- Simultaneous events: priority is ms > PCSrcE > lu.

Decomposition:
- Package hazard_pkg holds:
  - localparams FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - FSM state encoding ST_IDLE=2'b00, ST_WAIT=2'b01, ST_ERR=2'b10.
- Sub-module mem_wait_fsm (state, cnt, MemErr, ms output) is parametrised by MAX_WAIT.
- Forwarding, load-use and branch logic stay in the hazard_ctrl top.

Test Plan:
- Forwarding:
  - RegWriteM=1, RD_M=5, RegWriteW=1, RD_W=5, Rs1_E=5 -> ForwardAE=10.
  - Then RegWriteM=0 -> ForwardAE=01.
  - Rs2_E=0 with RD_M=0 -> ForwardBE=00.
- Load-use: ResultSrcE=1, RD_E=7, Rs2_D=7 -> StallF=StallD=FlushE=1 for 1 cycle, StallCount=1. Same with PCSrcE=1 -> StallF=0, FlushD=FlushE=1.
- Memory wait (MAX_WAIT=8): MemReqM=1, MemReadyM=0 for 3 cycles then 1 -> StallF..StallM=1 and FlushW=1 for 3 cycles, 0 on the ready cycle, FSM back in IDLE, StallCount=3.
- Timeout (MAX_WAIT=4): MemReqM=1, MemReadyM held 0 -> 5 stall cycles, then MemErr=1 from the 6th cycle; stalls stay 1; a later MemReadyM=1 has no effect.
- Reset mid-WAIT: rst low asynchronously after 2 wait cycles -> all outputs 0 immediately, MemErr=0, StallCount=0; after release with MemReqM=0 -> no stall.
- Saturation (CNT_W=3): 10 consecutive stall cycles -> StallCount stops at 7.
